bitplane_sequencer: RTL
=======================

# bitplane_sequencer

Controller that walks the bit-plane source through every bit position of a WORD_W-bit sample set and hands each LANES-wide plane to the downstream bit-serial datapath. For each position it drives the plane index, pulses the source's load strobe, waits the source's fixed latency, captures the plane, and offers it downstream on a valid/ready handshake. It sits between the top-level run control (start/abort/done) and the bit-plane source feeding the 64-lane bit-serial array.

## Interface
- WORD_W, 25: bits per sample; number of planes per run.
- LANES, 64: samples per plane (plane width).
- LOAD_LAT, 1: cycles from `load` pulse until `plane_in` is valid; legal range 1..15.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- busy  out  1  high from the cycle after accepted start until IDLE re-entered.
- done  out  1  one-cycle pulse after the last plane handshake.
- load  out  1  one-cycle strobe to the bit-plane source.
- bit_idx  out  32  plane index to the source; stable from the load cycle through capture.
- plane_in  in  LANES  plane returned by the source.
- out_valid  out  1  captured plane available.
- out_ready  in  1  downstream accepts the plane.
- out_plane  out  LANES  captured plane.
- out_idx  out  32  index of the plane on out_plane.
- out_last  out  1  high with out_valid on the final plane of the run.

## Operation
- States: IDLE, LOAD, WAIT, PRESENT, DONE.
- IDLE: start=1 -> LOAD; index := first index (0, MSB plane).
- LOAD: load=1 for exactly one cycle -> WAIT; latency counter := LOAD_LAT.
- WAIT: counter decrements each cycle; in the cycle it reaches 1, plane_in is registered into out_plane, bit_idx copied to out_idx -> PRESENT.
- PRESENT: out_valid=1; out_plane/out_idx/out_last held until out_valid & out_ready. On handshake: if index is last -> DONE, else index steps and -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- abort=1 in any state other than IDLE: next state IDLE, out_valid drops next cycle, no done pulse, index returns to first value. abort wins over a simultaneous handshake.
- start while busy is ignored; start and abort together in IDLE: abort ignored, run starts.
- Index width: internal counter is clog2(WORD_W) bits, zero-extended onto bit_idx/out_idx; never exceeds WORD_W-1.
- Reset: state IDLE; busy, done, load, out_valid, out_last = 0; bit_idx, out_idx, out_plane = 0.

## Timing
- Start sampled at edge 0 -> load high in cycle 1 -> out_valid first high in cycle LOAD_LAT+2.
- Per plane with out_ready held high: LOAD_LAT+2 cycles (LOAD, LOAD_LAT×WAIT, PRESENT).
- Full run with out_ready held high: WORD_W×(LOAD_LAT+2) cycles, done in the following cycle; default 75 cycles, done in cycle 76.
- out_ready low stalls PRESENT indefinitely; no plane is dropped or reloaded.
- load never asserted while out_valid is high.

## Configuration
- BITPLANE_LSB_FIRST_EN defined: index runs WORD_W-1 down to 0 (LSB plane first); out_last on index 0.
- Undefined (default): index runs 0 up to WORD_W-1 (MSB plane first); out_last on index WORD_W-1.

## Structure
- Package bitplane_pkg: state enum, default WORD_W/LANES constants, IDX_W = clog2(WORD_W), first/last index constants per order.
- One sub-module: bitplane_lat_counter (loadable down-counter, asserts expire when count is 1).

## Test plan
- Reset mid-PRESENT (rst_n low at plane 7) -> all outputs 0 immediately, IDLE; next start restarts at index 0.
- Default params, out_ready=1, start at cycle 0 -> 25 load pulses, out_idx 0..24 in order, out_last only with idx 24, done in cycle 76.
- Source returns plane = {LANES{idx[0]}} -> out_plane alternates all-0/all-1 matching out_idx.
- out_ready low 10 cycles on plane 3 -> out_valid, out_plane, out_idx=3 held, no extra load; resume gives idx 4.
- abort in WAIT of plane 12 -> IDLE next cycle, no done, busy low; start in same cycle as abort ignored.
- BITPLANE_LSB_FIRST_EN, LOAD_LAT=3 -> indices 24..0, 5 cycles per plane, out_last with idx 0, done at cycle 126.

Source files
------------

// File: rtl/bitplane_pkg.sv
// rtl/bitplane_pkg.sv - shared types and constants for the bit-plane sequencer
//
// Purpose : state encoding, default geometry, index width helper and the
//           first/last plane index for each walk order.
// Ports   : none (package).
// Config  : BITPLANE_LSB_FIRST_EN selects LSB-plane-first ordering in the
//           top level; both orders' constants live here.
package bitplane_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DEF_WORD_W   = 25;
   localparam int DEF_LANES    = 64;
   localparam int DEF_LOAD_LAT = 1;

   // Latency counter width; LOAD_LAT is limited to 1..15.
   localparam int LAT_CNT_W = 4;

   // A single-plane run still needs a one-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(DEF_WORD_W);

   // Index bounds for the default sample width, per walk order.
   localparam logic [IDX_W-1:0] MSB_ORDER_FIRST_IDX = '0;
   localparam logic [IDX_W-1:0] MSB_ORDER_LAST_IDX  = IDX_W'(DEF_WORD_W - 1);
   localparam logic [IDX_W-1:0] LSB_ORDER_FIRST_IDX = IDX_W'(DEF_WORD_W - 1);
   localparam logic [IDX_W-1:0] LSB_ORDER_LAST_IDX  = '0;

endpackage

// File: rtl/bitplane_lat_counter.sv
// rtl/bitplane_lat_counter.sv - loadable down-counter timing the source latency
//
// Purpose : loaded with the source latency while the load strobe is out,
//           counts down while waiting; expire flags the capture cycle.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           load_en      - load count_q with load_val
//           load_val     - latency in cycles (1..15)
//           dec_en       - decrement (saturates at zero)
//           expire       - high while the count is exactly 1
module bitplane_lat_counter
   import bitplane_pkg::*;
#(
   parameter int CNT_W = LAT_CNT_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec_en,
   output logic             expire
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_en) begin
         count_d = load_val;
      end else if (dec_en && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/bitplane_sequencer.sv
// rtl/bitplane_sequencer.sv - walks the bit-plane source through every plane of a run
//
// Purpose : per plane: drive bit_idx, strobe load, wait LOAD_LAT cycles,
//           capture plane_in and offer it downstream on valid/ready.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           start, abort, busy, done - run control
//           load, bit_idx, plane_in - bit-plane source side
//           out_valid, out_ready, out_plane, out_idx, out_last
//                                - downstream plane stream
// Config  : BITPLANE_LSB_FIRST_EN defined -> planes WORD_W-1 down to 0;
//           undefined -> planes 0 up to WORD_W-1.
module bitplane_sequencer
   import bitplane_pkg::*;
#(
   parameter int WORD_W   = DEF_WORD_W,
   parameter int LANES    = DEF_LANES,
   parameter int LOAD_LAT = DEF_LOAD_LAT
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             load,
   output logic [31:0]      bit_idx,
   input  logic [LANES-1:0] plane_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] out_plane,
   output logic [31:0]      out_idx,
   output logic             out_last
);

   localparam int LOC_IDX_W = idx_width(WORD_W);

`ifdef BITPLANE_LSB_FIRST_EN
   localparam logic [LOC_IDX_W-1:0] FIRST_IDX = LOC_IDX_W'(WORD_W - 1);
   localparam logic [LOC_IDX_W-1:0] LAST_IDX  = '0;
`else
   localparam logic [LOC_IDX_W-1:0] FIRST_IDX = '0;
   localparam logic [LOC_IDX_W-1:0] LAST_IDX  = LOC_IDX_W'(WORD_W - 1);
`endif

   state_t                 state_q,     state_d;
   logic [LOC_IDX_W-1:0]   idx_q,       idx_d;
   logic [LOC_IDX_W-1:0]   out_idx_q,   out_idx_d;
   logic [LANES-1:0]       out_plane_q, out_plane_d;
   logic                   busy_q,      busy_d;
   logic                   done_q,      done_d;
   logic                   load_q,      load_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q,  out_last_d;

   logic [LOC_IDX_W-1:0]   idx_step;
   logic                   lat_load;
   logic                   lat_dec;
   logic                   lat_expire;

`ifdef BITPLANE_LSB_FIRST_EN
   assign idx_step = idx_q - LOC_IDX_W'(1);
`else
   assign idx_step = idx_q + LOC_IDX_W'(1);
`endif

   assign lat_load = (state_q == ST_LOAD);
   assign lat_dec  = (state_q == ST_WAIT);

   bitplane_lat_counter #(
      .CNT_W    (LAT_CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (lat_load),
      .load_val (LAT_CNT_W'(LOAD_LAT)),
      .dec_en   (lat_dec),
      .expire   (lat_expire)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_idx_d   = out_idx_q;
      out_plane_d = out_plane_q;
      out_last_d  = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               idx_d   = FIRST_IDX;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_expire) begin
               out_plane_d = plane_in;
               out_idx_d   = idx_q;
               out_last_d  = (idx_q == LAST_IDX);
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_step;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including a same-cycle handshake; in
      // IDLE it is ignored so a simultaneous start still launches a run.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         idx_d   = FIRST_IDX;
      end

      // Outputs are registered copies of the next-state decode, so they
      // line up exactly with the state they describe.
      busy_d      = (state_d != ST_IDLE);
      load_d      = (state_d == ST_LOAD);
      out_valid_d = (state_d == ST_PRESENT);
      done_d      = (state_d == ST_DONE);
      if (state_d != ST_PRESENT) begin
         out_last_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         out_idx_q   <= '0;
         out_plane_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_idx_q   <= out_idx_d;
         out_plane_q <= out_plane_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_q      <= load_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign load      = load_q;
   assign bit_idx   = {{(32-LOC_IDX_W){1'b0}}, idx_q};
   assign out_valid = out_valid_q;
   assign out_plane = out_plane_q;
   assign out_idx   = {{(32-LOC_IDX_W){1'b0}}, out_idx_q};
   assign out_last  = out_last_q;

endmodule
